capture_readout_ctrl: RTL and testbench

- Sequences firmware readout of the captured sample buffer after a measurement reaches FINISH.
- Accepts a read request (base address, length), then drives the buffer's read port, which has 1-cycle read latency.
- Streams the samples out on a valid/ready interface with full backpressure support.
- Sits between the capture buffer and the firmware-facing data path; validates each request against the system controller's data_count.

---
 rtl/capture_readout_if.sv | 37 +++
 rtl/capture_readout_ctrl.sv | 168 ++++++++++++++++
 tb/tb_capture_readout_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_readout_if.sv
// Capture-buffer readout bus: request, buffer read port and output stream.
// master: the readout controller. slave: the firmware/buffer side.
interface capture_readout_if #(
  parameter int FIFO_SIZE  = 1024,
  parameter int DATA_WIDTH = 32
);
  localparam int ADDR_WIDTH = $clog2(FIFO_SIZE);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  logic                  start_read;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic [CNT_WIDTH-1:0]  rd_len;
  logic [CNT_WIDTH-1:0]  data_count;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;
  logic                  done;
  logic                  event_start_read_when_busy;
  logic                  event_read_len_invalid;

  modport master (
    input  start_read, rd_base, rd_len, data_count, mem_rd_data, m_ready,
    output mem_rd_en, mem_rd_addr, m_data, m_valid, m_last, busy, done,
           event_start_read_when_busy, event_read_len_invalid
  );

  modport slave (
    output start_read, rd_base, rd_len, data_count, mem_rd_data, m_ready,
    input  mem_rd_en, mem_rd_addr, m_data, m_valid, m_last, busy, done,
           event_start_read_when_busy, event_read_len_invalid
  );
endinterface

// File: rtl/capture_readout_ctrl.sv
// Capture buffer readout sequencer: validates a (base, len) request against
// data_count, issues reads to a 1-cycle-latency buffer port and streams the
// samples through a 2-entry output buffer with full valid/ready backpressure.
// Optional READOUT_WRAP_EN: allow requests that roll over the buffer end.
module capture_readout_ctrl #(
  parameter int FIFO_SIZE  = 1024,
  parameter int ADDR_WIDTH = $clog2(FIFO_SIZE),
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  capture_readout_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [CNT_WIDTH-1:0]  beat_left_q, beat_left_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  done_q, done_d;
  logic                  ev_busy_q, ev_busy_d;
  logic                  ev_inv_q, ev_inv_d;

  logic                  req_ok;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ_after;

`ifndef READOUT_WRAP_EN
  localparam logic [CNT_WIDTH:0] LIMIT = (CNT_WIDTH+1)'(FIFO_SIZE);
  logic [CNT_WIDTH:0] end_addr;
`endif

  // Request validation; end address is one bit wider so base+len cannot overflow.
  always_comb begin
    req_ok = (bus.rd_len != '0) && (bus.rd_len <= bus.data_count);
`ifndef READOUT_WRAP_EN
    end_addr = {2'b00, bus.rd_base} + {1'b0, bus.rd_len};
    req_ok   = req_ok && (end_addr <= LIMIT);
`endif
  end

  // Issue gating: buffer entries + read in flight - leaving beat must stay below 2.
  always_comb begin
    pop       = (occ_q != 2'd0) && bus.m_ready;
    occ_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == READ) && (issue_left_q != '0) && (occ_after < 3'd2);
  end

  // Next-state, address/count bookkeeping and output buffer update.
  always_comb begin
    state_d      = state_q;
    issue_addr_d = issue_addr_q;
    rd_addr_d    = rd_addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    inflight_d   = issue;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    occ_d        = occ_q;
    done_d       = 1'b0;
    ev_busy_d    = bus.start_read && (state_q != IDLE);
    ev_inv_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_read) begin
          if (req_ok) begin
            issue_addr_d = bus.rd_base;
            issue_left_d = bus.rd_len;
            beat_left_d  = bus.rd_len;
            state_d      = READ;
          end else begin
            ev_inv_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          rd_addr_d    = issue_addr_q;
          issue_addr_d = issue_addr_q + ADDR_WIDTH'(1);
          issue_left_d = issue_left_q - CNT_WIDTH'(1);
          if (issue_left_q == CNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (beat_left_q == CNT_WIDTH'(1))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) beat_left_d = beat_left_q - CNT_WIDTH'(1);

    // Head is always buf0; a simultaneous push and pop shifts buf1 forward
    // and lands the new sample behind whatever remains.
    case ({inflight_q, pop})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = bus.mem_rd_data;
        else               buf1_d = bus.mem_rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = bus.mem_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_addr_q <= '0;
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      inflight_q   <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      occ_q        <= 2'd0;
      done_q       <= 1'b0;
      ev_busy_q    <= 1'b0;
      ev_inv_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_addr_q <= issue_addr_d;
      rd_addr_q    <= rd_addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      inflight_q   <= inflight_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      occ_q        <= occ_d;
      done_q       <= done_d;
      ev_busy_q    <= ev_busy_d;
      ev_inv_q     <= ev_inv_d;
    end
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = issue ? issue_addr_q : rd_addr_q;
  assign bus.m_valid     = (occ_q != 2'd0);
  assign bus.m_data      = buf0_q;
  assign bus.m_last      = (occ_q != 2'd0) && (beat_left_q == CNT_WIDTH'(1));
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.event_start_read_when_busy = ev_busy_q;
  assign bus.event_read_len_invalid     = ev_inv_q;

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Scoreboard bench for capture_readout_ctrl with a 1-cycle-latency buffer model.
module tb_capture_readout_ctrl;
  localparam int FIFO_SIZE = 1024;
  localparam int AW = 10;
  localparam int CW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  capture_readout_if #(.FIFO_SIZE(FIFO_SIZE), .DATA_WIDTH(DW)) bus ();
  capture_readout_ctrl #(.FIFO_SIZE(FIFO_SIZE), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_mode = 0;
  int en_cnt = 0;
  int pop_cnt = 0;
  int outstanding = 0;
  int max_out = 0;
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {6'h2B, a, 6'h15, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = AW'(int'(base) + i);
      addr_q.push_back(a);
      exp_q.push_back({(i == len - 1), mem_word(a)});
    end
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // buffer read port model, 1-cycle latency
  initial forever begin
    @(posedge clk);
    if (rst) bus.mem_rd_data <= '0;
    else if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_rd_addr);
  end

  // downstream ready: 0 always, 1 pattern 1,0,0,1, 2 random
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: read addresses, output beats, stall stability, occupancy bound
  initial begin
    logic          stall_p;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic [DW:0]   e;
    stall_p = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_p = 1'b0;
      end else begin
        if (bus.mem_rd_en) begin
          en_cnt++;
          outstanding++;
          if (addr_q.size() == 0) check("rd_extra", 1, 0);
          else check("rd_addr", bus.mem_rd_addr, addr_q.pop_front());
        end
        if (stall_p) begin
          check("stall_valid", bus.m_valid, 1);
          check("stall_data", bus.m_data, stall_data);
          check("stall_last", bus.m_last, stall_last);
        end
        if (bus.m_valid && bus.m_ready) begin
          pop_cnt++;
          outstanding--;
          if (exp_q.size() == 0) check("beat_extra", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("m_data", bus.m_data, e[DW-1:0]);
            check("m_last", bus.m_last, e[DW]);
          end
        end
        if (outstanding > max_out) max_out = outstanding;
        stall_p    = bus.m_valid && !bus.m_ready;
        stall_data = bus.m_data;
        stall_last = bus.m_last;
      end
    end
  end

  task automatic req(input logic [AW-1:0] base, input logic [CW-1:0] len,
                     input logic [CW-1:0] dc, input bit ok, input bit was_busy);
    @(posedge clk);
    #1;
    if (ok && !was_busy) push_exp(base, int'(len));
    bus.start_read = 1'b1;
    bus.rd_base    = base;
    bus.rd_len     = len;
    bus.data_count = dc;
    @(posedge clk);
    #1;
    bus.start_read = 1'b0;
    @(negedge clk);
    check("ev_invalid", bus.event_read_len_invalid, (!ok && !was_busy));
    check("ev_busy", bus.event_start_read_when_busy, was_busy);
    if (!was_busy) check("busy_after_req", bus.busy, ok);
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check(tag, seen, 1);
    if (seen) check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  function automatic logic [63:0] all_outs();
    return {15'd0, bus.mem_rd_en, bus.mem_rd_addr, bus.m_valid, bus.m_data, bus.m_last,
            bus.busy, bus.done, bus.event_start_read_when_busy, bus.event_read_len_invalid};
  endfunction

  initial begin
    logic [9:0] en_v, val_v, last_v, done_v, busy_v;
    int e0, p0;
    rst = 1'b1;
    bus.start_read = 1'b0;
    bus.rd_base = '0;
    bus.rd_len = '0;
    bus.data_count = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);

    // 1: latency profile, base 0 len 4, ready held high
    ready_mode = 0;
    @(posedge clk);
    #1;
    push_exp(0, 4);
    bus.start_read = 1'b1;
    bus.rd_base = '0;
    bus.rd_len = CW'(4);
    bus.data_count = CW'(1024);
    en_v = '0; val_v = '0; last_v = '0; done_v = '0; busy_v = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_v[i]   = bus.mem_rd_en;
      val_v[i]  = bus.m_valid;
      last_v[i] = bus.m_last;
      done_v[i] = bus.done;
      busy_v[i] = bus.busy;
      if (i == 0) begin
        @(posedge clk);
        #1;
        bus.start_read = 1'b0;
      end
    end
    check("t1_rd_en", en_v, 10'b00_0001_1110);
    check("t1_valid", val_v, 10'b00_0111_1000);
    check("t1_last", last_v, 10'b00_0100_0000);
    check("t1_done", done_v, 10'b00_1000_0000);
    check("t1_busy", busy_v, 10'b00_0111_1110);
    check("t1_left", exp_q.size(), 0);

    // 2: len 8 with ready 1,0,0,1; data_count change after request ignored
    ready_mode = 1;
    req(16, 8, 1024, 1, 0);
    bus.data_count = '0;
    wait_done(100, "t2_done");

    // 3: rejected requests issue nothing; len == data_count accepted
    ready_mode = 0;
    e0 = en_cnt;
    req(5, 101, 100, 0, 0);
    req(5, 0, 100, 0, 0);
    repeat (3) @(negedge clk);
    check("t3_no_rd", en_cnt - e0, 0);
    check("t3_idle", bus.busy, 0);
    req(5, 100, 100, 1, 0);
    wait_done(300, "t3_done");

    // 4: end-of-buffer boundary and rollover
    ready_mode = 2;
    req(1016, 8, 1024, 1, 0);
    wait_done(200, "t4_fit");
`ifdef READOUT_WRAP_EN
    req(1020, 8, 1024, 1, 0);
    wait_done(200, "t4_wrap");
`else
    req(1020, 8, 1024, 0, 0);
    repeat (3) @(negedge clk);
    check("t4_wrap_idle", bus.busy, 0);
`endif

    // 5: start_read while busy is flagged and ignored
    ready_mode = 2;
    p0 = pop_cnt;
    req(100, 16, 1024, 1, 0);
    repeat (3) @(posedge clk);
    req(7, 3, 1024, 0, 1);
    wait_done(300, "t5_done");
    check("t5_beats", pop_cnt - p0, 16);

    // 6: reset mid-transfer, then a fresh request
    ready_mode = 0;
    p0 = pop_cnt;
    req(200, 16, 1024, 1, 0);
    for (int i = 0; i < 50 && (pop_cnt - p0) < 5; i++) @(negedge clk);
    check("t6_reached5", ((pop_cnt - p0) >= 5), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_reset_outputs", all_outs(), 0);
    req(0, 2, 1024, 1, 0);
    wait_done(50, "t6_done");

    check("max_outstanding", max_out, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
